// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery multiplier; X^E mod M.
// Optional LEADING_ZERO_SKIP_EN: skip squarings of the Montgomery one before the first set exponent bit.
module montgomery_exp_ctrl #(
    parameter int DATA_W = 1024,
    parameter int EXP_W  = 1024,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_x,
    input  logic [EXP_W-1:0]  in_e,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_r2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              mm_start,
    output logic [DATA_W-1:0] mm_a,
    output logic [DATA_W-1:0] mm_b,
    input  logic [DATA_W-1:0] mm_result,
    input  logic              mm_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TOMONT_ISSUE,
        S_WAIT,
        S_SCAN,
        S_SQR_ISSUE,
        S_MUL_ISSUE,
        S_NEXT,
        S_FROM_ISSUE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_TOMONT,
        OP_SQR,
        OP_MUL,
        OP_FROM
    } op_t;

    state_t            state;
    op_t               op;
    logic [DATA_W-1:0] x_reg;
    logic [DATA_W-1:0] r2_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] xt_reg;
    logic [EXP_W-1:0]  e_reg;
    logic [CNT_W-1:0]  idx;
`ifdef LEADING_ZERO_SKIP_EN
    logic              seen_one;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            op       <= OP_TOMONT;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            x_reg    <= '0;
            r2_reg   <= '0;
            a_reg    <= '0;
            xt_reg   <= '0;
            e_reg    <= '0;
            idx      <= '0;
`ifdef LEADING_ZERO_SKIP_EN
            seen_one <= 1'b0;
`endif
        end else begin
            mm_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_reg  <= in_x;
                        e_reg  <= in_e;
                        r2_reg <= in_r2;
                        a_reg  <= in_r;
                        idx    <= CNT_W'(EXP_W - 1);
                        busy   <= 1'b1;
`ifdef LEADING_ZERO_SKIP_EN
                        seen_one <= 1'b0;
`endif
                        state  <= S_TOMONT_ISSUE;
                    end
                end
                S_TOMONT_ISSUE: begin
                    mm_a     <= x_reg;
                    mm_b     <= r2_reg;
                    mm_start <= 1'b1;
                    op       <= OP_TOMONT;
                    state    <= S_WAIT;
                end
                S_SCAN: begin
`ifdef LEADING_ZERO_SKIP_EN
                    // A_reg is still the Montgomery one, so squaring it changes nothing
                    if (!seen_one && !e_reg[idx]) begin
                        state <= S_NEXT;
                    end else begin
                        seen_one <= 1'b1;
                        state    <= S_SQR_ISSUE;
                    end
`else
                    state <= S_SQR_ISSUE;
`endif
                end
                S_SQR_ISSUE: begin
                    mm_a     <= a_reg;
                    mm_b     <= a_reg;
                    mm_start <= 1'b1;
                    op       <= OP_SQR;
                    state    <= S_WAIT;
                end
                S_MUL_ISSUE: begin
                    mm_a     <= a_reg;
                    mm_b     <= xt_reg;
                    mm_start <= 1'b1;
                    op       <= OP_MUL;
                    state    <= S_WAIT;
                end
                S_NEXT: begin
                    if (idx == '0) begin
                        state <= S_FROM_ISSUE;
                    end else begin
                        idx   <= idx - CNT_W'(1);
                        state <= S_SCAN;
                    end
                end
                S_FROM_ISSUE: begin
                    mm_a     <= a_reg;
                    mm_b     <= DATA_W'(1);
                    mm_start <= 1'b1;
                    op       <= OP_FROM;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (mm_done) begin
                        case (op)
                            OP_TOMONT: begin
                                xt_reg <= mm_result;
                                state  <= S_SCAN;
                            end
                            OP_SQR: begin
                                a_reg <= mm_result;
                                state <= e_reg[idx] ? S_MUL_ISSUE : S_NEXT;
                            end
                            OP_MUL: begin
                                a_reg <= mm_result;
                                state <= S_NEXT;
                            end
                            default: begin
                                result <= mm_result;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                state  <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Bench for montgomery_exp_ctrl: behavioural Montgomery multiplier (M=241, R=2^1024, variable latency)
// and a result scoreboard; table-driven exponentiations plus restart/reset corner sequences.
module tb_montgomery_exp_ctrl;
    localparam int DW = 1024;
    localparam int EW = 8;
    localparam int CW = 3;
    localparam longint M = 241;
`ifdef LEADING_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] in_x;
    logic [EW-1:0] in_e;
    logic [DW-1:0] in_r;
    logic [DW-1:0] in_r2;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic          mm_start;
    logic [DW-1:0] mm_a;
    logic [DW-1:0] mm_b;
    logic [DW-1:0] mm_result = '0;
    logic          mm_done = 1'b0;

    montgomery_exp_ctrl #(.DATA_W(DW), .EXP_W(EW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_x(in_x), .in_e(in_e),
        .in_r(in_r), .in_r2(in_r2), .busy(busy), .done(done), .result(result),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat = 5;
    int mm_cnt = 0;
    int stab_err = 0;
    int done_cnt = 0;
    longint r_mod, r2_mod, rinv;
    logic [DW-1:0] ma, mb;
    int  cnt;
    bit  pend = 1'b0;
    int  q[$];

    function automatic longint mont(input longint a, input longint b);
        return (((a * b) % M) * rinv) % M;
    endfunction

    function automatic int ref_pow(input int x, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * x) % M;
        return int'(r);
    endfunction

    function automatic int ref_ops(input int e);
        int pc = 0;
        int msb = -1;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) begin
                pc++;
                msb = i;
            end
        end
        if (!SKIP) return 2 + EW + pc;
        return 2 + (msb + 1) + pc;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act[63:0], expv[63:0]);
        end
    endtask

    // Multiplier model: latches operands on mm_start, answers after lat cycles.
    always @(posedge clk) begin
        mm_done <= 1'b0;
        if (mm_start) begin
            mm_cnt++;
            ma = mm_a;
            mb = mm_b;
            if (lat <= 1) begin
                pend = 1'b0;
                mm_done   <= 1'b1;
                mm_result <= DW'(mont(longint'(mm_a[31:0]), longint'(mm_b[31:0])));
            end else begin
                cnt  = lat - 1;
                pend = 1'b1;
            end
        end else if (pend) begin
            if (mm_a !== ma || mm_b !== mb) stab_err++;
            cnt--;
            if (cnt == 0) begin
                pend = 1'b0;
                mm_done   <= 1'b1;
                mm_result <= DW'(mont(longint'(ma[31:0]), longint'(mb[31:0])));
            end
        end
    end

    // Scoreboard consumer
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious_done actual result %0h expected no done", result[63:0]);
            end else begin
                int ev;
                ev = q.pop_front();
                if (result !== DW'(ev)) begin
                    errors++;
                    $display("FAIL sb_result actual %0d expected %0d", result[63:0], ev);
                end
            end
        end
    end

    task automatic drive_start(input int x, input int e);
        in_x  = DW'(x);
        in_e  = EW'(e);
        in_r  = DW'(r_mod);
        in_r2 = DW'(r2_mod);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, DW'(done), DW'(1));
    endtask

    task automatic run_vec(input int x, input int e, input int l, input int exp_r, input int exp_n);
        int d0, base, sbase;
        lat = l;
        @(negedge clk);
        d0    = done_cnt;
        base  = mm_cnt;
        sbase = stab_err;
        q.push_back(exp_r);
        drive_start(x, e);
        check("busy_after_start", DW'(busy), DW'(1));
        wait_done("run");
        check("busy_at_done", DW'(busy), DW'(0));
        repeat (3) @(negedge clk);
        check("done_pulses", DW'(done_cnt - d0), DW'(1));
        check("result_held", result, DW'(exp_r));
        check("mm_start_count", DW'(mm_cnt - base), DW'(exp_n));
        check("operand_stable", DW'(stab_err - sbase), DW'(0));
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        check("rst_result", result, '0);
        check("rst_mm_start", DW'(mm_start), DW'(0));
        check("rst_mm_a", mm_a, '0);
        check("rst_mm_b", mm_b, '0);
    endtask

    typedef struct {
        int x;
        int e;
        int l;
        int exp_r;
        int exp_n;
    } vec_t;

    vec_t vt[7];

    initial begin
        int d0, base, n;
        reset = 1'b1;
        start = 1'b0;
        in_x = '0; in_e = '0; in_r = '0; in_r2 = '0;

        r_mod = 1;
        for (int i = 0; i < DW; i++) r_mod = (r_mod * 2) % M;
        r2_mod = (r_mod * r_mod) % M;
        rinv = 0;
        for (longint i = 1; i < M; i++) if ((r_mod * i) % M == 1) rinv = i;

        vt[0] = '{5, 3, 5, 125, SKIP ? 6 : 12};
        vt[1] = '{5, 11, 5, 79, SKIP ? 9 : 13};
        vt[2] = '{7, 0, 5, 1, SKIP ? 2 : 10};
        vt[3] = '{5, 11, 1, 79, SKIP ? 9 : 13};
        vt[4] = '{5, 11, 40, 79, SKIP ? 9 : 13};
        vt[5] = '{2, 8, 3, 15, SKIP ? 7 : 11};
        vt[6] = '{200, 37, 7, ref_pow(200, 37), ref_ops(37)};

        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vt[i].x, vt[i].e, vt[i].l, vt[i].exp_r, vt[i].exp_n);

        // Restarts mid-run and coincident with mm_done must be ignored.
        lat = 5;
        @(negedge clk);
        d0 = done_cnt;
        base = mm_cnt;
        q.push_back(79);
        drive_start(5, 11);
        repeat (10) @(negedge clk);
        drive_start(7, 0);
        n = 0;
        while (!mm_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("restart_sync_mm_done", DW'(mm_done), DW'(1));
        drive_start(2, 8);
        wait_done("restart");
        repeat (3) @(negedge clk);
        check("restart_done_pulses", DW'(done_cnt - d0), DW'(1));
        check("restart_result", result, DW'(79));
        check("restart_mm_count", DW'(mm_cnt - base), DW'(SKIP ? 9 : 13));

        // Reset during the WAIT of a squaring; the late multiplier answer lands in IDLE.
        lat = 40;
        @(negedge clk);
        base = mm_cnt;
        q.push_back(79);
        drive_start(5, 11);
        n = 0;
        while (mm_cnt - base < 2 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reached_sqr", DW'(mm_cnt - base), DW'(2));
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        d0 = done_cnt;
        repeat (60) @(negedge clk);
        check("no_stale_done", DW'(done_cnt - d0), DW'(0));
        run_vec(2, 8, 5, 15, SKIP ? 7 : 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
